bf_prog_loader: RTL and testbench

Upstream stage of the BF program memory. Accepts a host byte stream on a valid/ready handshake and discards every non-command character. Writes the surviving BF commands sequentially into program memory, then appends a 0x00 terminator. Checks bracket balance and capacity, and holds the BF core in reset until a clean program is resident.

---
 rtl/bf_prog_loader.sv | 170 +++++++++++++++++
 tb/tb_bf_prog_loader.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_prog_loader.sv
// BF program loader: filters a host byte stream down to BF commands, stores them
// sequentially with a 0x00 terminator, and holds the core in reset until a clean load.
module bf_prog_loader #(
   parameter int PROG_ADDR_SIZE = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [7:0]                byte_in,
   input  logic                      byte_valid,
   input  logic                      byte_last,
   output logic                      byte_ready,
   input  logic                      load_start,
   output logic [PROG_ADDR_SIZE-1:0] prog_addr,
   output logic [7:0]                prog_data,
   output logic                      prog_we,
   output logic                      core_reset,
   output logic [PROG_ADDR_SIZE-1:0] prog_len,
   output logic                      loaded,
   output logic                      err_overflow,
   output logic                      err_unbalanced
);
   localparam int AW = PROG_ADDR_SIZE;
   localparam logic [AW-1:0] CNT_MAX   = {AW{1'b1}};
   localparam logic [AW-1:0] CNT_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   DEPTH_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_LOAD, ST_TERM, ST_RUN, ST_ERROR} state_t;

   function automatic logic is_cmd(input logic [7:0] b);
      case (b)
         8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_cmd = 1'b1;
         default:                                                is_cmd = 1'b0;
      endcase
   endfunction

   state_t        r_state;
   logic [AW-1:0] r_count;
   logic [AW:0]   r_depth;
   logic          r_prog_we;
   logic [AW-1:0] r_prog_addr;
   logic [7:0]    r_prog_data;
   logic [AW-1:0] r_prog_len;
   logic          r_err_ovf;
   logic          r_err_unb;

   state_t        w_state_nxt;
   logic [AW-1:0] w_count_nxt;
   logic [AW:0]   w_depth_nxt;
   logic          w_we_nxt;
   logic [AW-1:0] w_addr_nxt;
   logic [7:0]    w_data_nxt;
   logic [AW-1:0] w_len_nxt;
   logic          w_ovf_nxt;
   logic          w_unb_nxt;

   logic          w_xfer;
   logic          w_is_cmd;
   logic          w_is_open;
   logic          w_is_close;
   logic [AW:0]   w_depth_upd;

   assign byte_ready = (r_state == ST_LOAD) && !reset;
   assign core_reset = (r_state != ST_RUN);
   assign loaded     = (r_state == ST_RUN);

   assign prog_we        = r_prog_we;
   assign prog_addr      = r_prog_addr;
   assign prog_data      = r_prog_data;
   assign prog_len       = r_prog_len;
   assign err_overflow   = r_err_ovf;
   assign err_unbalanced = r_err_unb;

   assign w_xfer     = byte_valid && byte_ready;
   assign w_is_cmd   = is_cmd(byte_in);
   assign w_is_open  = (byte_in == 8'h5B);
   assign w_is_close = (byte_in == 8'h5D);

   // A close at depth 0 is trapped as an error before this value is ever used.
   always_comb begin
      w_depth_upd = r_depth;
      if (w_is_open)
         w_depth_upd = r_depth + DEPTH_ONE;
      else if (w_is_close)
         w_depth_upd = r_depth - DEPTH_ONE;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_depth_nxt = r_depth;
      w_we_nxt    = 1'b0;
      w_addr_nxt  = r_prog_addr;
      w_data_nxt  = r_prog_data;
      w_len_nxt   = r_prog_len;
      w_ovf_nxt   = r_err_ovf;
      w_unb_nxt   = r_err_unb;
      case (r_state)
         ST_LOAD: begin
            if (w_xfer) begin
               if (w_is_cmd && (r_count == CNT_MAX)) begin
                  w_ovf_nxt   = 1'b1;
                  w_state_nxt = ST_ERROR;
               end else if (w_is_close && (r_depth == '0)) begin
                  w_unb_nxt   = 1'b1;
                  w_state_nxt = ST_ERROR;
               end else begin
                  if (w_is_cmd) begin
                     w_we_nxt    = 1'b1;
                     w_addr_nxt  = r_count;
                     w_data_nxt  = byte_in;
                     w_count_nxt = r_count + CNT_ONE;
                     w_depth_nxt = w_depth_upd;
                  end
                  if (byte_last) begin
                     if (w_depth_upd != '0) begin
                        w_unb_nxt   = 1'b1;
                        w_state_nxt = ST_ERROR;
                     end else begin
                        w_state_nxt = ST_TERM;
                     end
                  end
               end
            end
         end
         ST_TERM: begin
            // r_count already includes the final command written on the previous edge.
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_count;
            w_data_nxt  = 8'h00;
            w_len_nxt   = r_count;
            w_state_nxt = ST_RUN;
         end
         default: begin
            if (load_start) begin
               w_state_nxt = ST_LOAD;
               w_count_nxt = '0;
               w_depth_nxt = '0;
               w_len_nxt   = '0;
               w_ovf_nxt   = 1'b0;
               w_unb_nxt   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_LOAD;
         r_count     <= '0;
         r_depth     <= '0;
         r_prog_we   <= 1'b0;
         r_prog_addr <= '0;
         r_prog_data <= 8'h00;
         r_prog_len  <= '0;
         r_err_ovf   <= 1'b0;
         r_err_unb   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_depth     <= w_depth_nxt;
         r_prog_we   <= w_we_nxt;
         r_prog_addr <= w_addr_nxt;
         r_prog_data <= w_data_nxt;
         r_prog_len  <= w_len_nxt;
         r_err_ovf   <= w_ovf_nxt;
         r_err_unb   <= w_unb_nxt;
      end
   end

endmodule

// File: tb/tb_bf_prog_loader.sv
// Bench for bf_prog_loader: directed scenarios plus random streams scored against
// a string-level model of filtering, bracket balance and capacity.
module tb_bf_prog_loader;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset, byte_valid, byte_last, load_start;
   logic [7:0] byte_in;

   logic        b_ready, b_we, b_core, b_loaded, b_ovf, b_unb;
   logic [15:0] b_addr, b_len;
   logic [7:0]  b_data;
   logic        s_ready, s_we, s_core, s_loaded, s_ovf, s_unb;
   logic [2:0]  s_addr, s_len;
   logic [7:0]  s_data;

   logic        sel_small = 1'b0;
   logic        byte_ready, prog_we, core_reset, loaded, err_overflow, err_unbalanced;
   logic [15:0] prog_addr, prog_len;
   logic [7:0]  prog_data;

   bf_prog_loader #(.PROG_ADDR_SIZE(16)) u_big (
      .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_last(byte_last), .byte_ready(b_ready), .load_start(load_start),
      .prog_addr(b_addr), .prog_data(b_data), .prog_we(b_we), .core_reset(b_core),
      .prog_len(b_len), .loaded(b_loaded), .err_overflow(b_ovf), .err_unbalanced(b_unb));

   bf_prog_loader #(.PROG_ADDR_SIZE(3)) u_small (
      .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_last(byte_last), .byte_ready(s_ready), .load_start(load_start),
      .prog_addr(s_addr), .prog_data(s_data), .prog_we(s_we), .core_reset(s_core),
      .prog_len(s_len), .loaded(s_loaded), .err_overflow(s_ovf), .err_unbalanced(s_unb));

   assign byte_ready     = sel_small ? s_ready  : b_ready;
   assign prog_we        = sel_small ? s_we     : b_we;
   assign core_reset     = sel_small ? s_core   : b_core;
   assign loaded         = sel_small ? s_loaded : b_loaded;
   assign err_overflow   = sel_small ? s_ovf    : b_ovf;
   assign err_unbalanced = sel_small ? s_unb    : b_unb;
   assign prog_addr      = sel_small ? {13'd0, s_addr} : b_addr;
   assign prog_len       = sel_small ? {13'd0, s_len}  : b_len;
   assign prog_data      = sel_small ? s_data : b_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] stim[$];
   int wr_addr[$];
   int wr_data[$];
   int exp_addr[$];
   int exp_data[$];
   int   exp_len;
   logic exp_ovf, exp_unb, exp_run;

   always @(negedge clock) begin
      if (prog_we === 1'b1) begin
         wr_addr.push_back(int'(prog_addr));
         wr_data.push_back(int'(prog_data));
      end
   end

   task automatic set_stim(input string s);
      stim.delete();
      for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   // Reference: walk the stream as text, keep only command characters, stop at the first error.
   task automatic model(input int cap);
      string cmds;
      int    depth;
      int    n;
      logic  c;
      cmds = "+-<>.,[]";
      exp_addr.delete();
      exp_data.delete();
      exp_len = 0; exp_ovf = 1'b0; exp_unb = 1'b0; exp_run = 1'b0;
      depth = 0; n = 0;
      for (int i = 0; i < stim.size(); i++) begin
         c = 1'b0;
         for (int k = 0; k < 8; k++) if (stim[i] == cmds[k]) c = 1'b1;
         if (c && n == cap - 1) begin exp_ovf = 1'b1; return; end
         if (stim[i] == "]" && depth == 0) begin exp_unb = 1'b1; return; end
         if (c) begin
            exp_addr.push_back(n);
            exp_data.push_back(int'(stim[i]));
            n++;
            if (stim[i] == "[") depth++;
            if (stim[i] == "]") depth--;
         end
         if (i == stim.size() - 1) begin
            if (depth != 0) exp_unb = 1'b1;
            else begin
               exp_addr.push_back(n);
               exp_data.push_back(0);
               exp_len = n;
               exp_run = 1'b1;
            end
         end
      end
   endtask

   task automatic send(input int gap_mode, input bit with_last);
      int idle;
      for (int i = 0; i < stim.size(); i++) begin
         idle = 0;
         if (gap_mode == 1) idle = 1;
         if (gap_mode == 2) idle = $urandom_range(0, 2);
         repeat (idle) begin byte_valid = 1'b0; @(negedge clock); end
         byte_in    = stim[i];
         byte_last  = with_last && (i == stim.size() - 1);
         byte_valid = 1'b1;
         #1;
         if (byte_ready !== 1'b1) break;
         @(posedge clock);
         @(negedge clock);
      end
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic restart();
      reset = 1'b1; byte_valid = 1'b0; byte_last = 1'b0; load_start = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      clear_log();
   endtask

   task automatic pulse_load_start();
      @(negedge clock);
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(negedge clock);
      #1;
   endtask

   task automatic test_reset();
      clear_log();
      reset = 1'b1; byte_valid = 1'b1; byte_in = 8'h2B; byte_last = 1'b1; load_start = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      n_tests++;
      if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", byte_ready); end
      n_tests++;
      if (prog_we !== 1'b0 || prog_addr !== 16'd0 || prog_data !== 8'd0) begin
         n_fail++; $display("FAIL rst_write got we=%b a=%0h d=%0h want 0/0/0", prog_we, prog_addr, prog_data);
      end
      n_tests++;
      if (prog_len !== 16'd0 || loaded !== 1'b0 || core_reset !== 1'b1) begin
         n_fail++; $display("FAIL rst_ctrl got len=%0d ld=%b cr=%b want 0/0/1", prog_len, loaded, core_reset);
      end
      n_tests++;
      if (err_overflow !== 1'b0 || err_unbalanced !== 1'b0) begin
         n_fail++; $display("FAIL rst_err got %b%b want 00", err_overflow, err_unbalanced);
      end
      reset = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
      #1;
      n_tests++;
      if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b want 1", byte_ready); end
      repeat (3) @(negedge clock);
      n_tests++;
      if (wr_addr.size() != 0) begin n_fail++; $display("FAIL rst_no_write got %0d writes want 0", wr_addr.size()); end
   endtask

   task automatic test_basic();
      restart();
      set_stim("+[->+<].");
      model(65536);
      send(0, 1'b1);
      #1;
      n_tests++;
      if (prog_we !== 1'b1 || prog_addr !== 16'd7 || prog_data !== 8'h2E || loaded !== 1'b0) begin
         n_fail++; $display("FAIL basic_last_wr got we=%b a=%0d d=%0h ld=%b want 1/7/2e/0", prog_we, prog_addr, prog_data, loaded);
      end
      @(negedge clock); #1;
      n_tests++;
      if (prog_we !== 1'b1 || prog_addr !== 16'd8 || prog_data !== 8'h00) begin
         n_fail++; $display("FAIL basic_term got we=%b a=%0d d=%0h want 1/8/00", prog_we, prog_addr, prog_data);
      end
      n_tests++;
      if (loaded !== 1'b1 || core_reset !== 1'b0 || prog_len !== 16'd8) begin
         n_fail++; $display("FAIL basic_run got ld=%b cr=%b len=%0d want 1/0/8", loaded, core_reset, prog_len);
      end
      @(negedge clock); #1;
      n_tests++;
      if (prog_we !== 1'b0 || prog_addr !== 16'd8) begin
         n_fail++; $display("FAIL basic_hold got we=%b a=%0d want 0/8", prog_we, prog_addr);
      end
      settle();
      n_tests++;
      if (wr_addr.size() != exp_addr.size()) begin
         n_fail++; $display("FAIL basic_nwr got %0d want %0d", wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
         n_tests++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL basic_wr[%0d] got %0d=%0h want %0d=%0h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_filter();
      pulse_load_start();
      clear_log();
      set_stim("a+ b\n-");
      model(65536);
      send(0, 1'b1);
      settle();
      n_tests++;
      if (wr_addr.size() != exp_addr.size()) begin
         n_fail++; $display("FAIL filter_nwr got %0d want %0d", wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
         n_tests++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL filter_wr[%0d] got %0d=%0h want %0d=%0h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
      n_tests++;
      if (prog_len !== 16'd2 || loaded !== 1'b1) begin
         n_fail++; $display("FAIL filter_len got len=%0d ld=%b want 2/1", prog_len, loaded);
      end
   endtask

   task automatic test_unbalanced();
      restart();
      set_stim("]+");
      send(0, 1'b1);
      n_tests++;
      if (err_unbalanced !== 1'b1 || byte_ready !== 1'b0 || core_reset !== 1'b1 || prog_we !== 1'b0) begin
         n_fail++; $display("FAIL unb_close got unb=%b rdy=%b cr=%b we=%b want 1/0/1/0", err_unbalanced, byte_ready, core_reset, prog_we);
      end
      settle();
      n_tests++;
      if (wr_addr.size() != 0) begin n_fail++; $display("FAIL unb_close_nwr got %0d want 0", wr_addr.size()); end
      restart();
      set_stim("[[+]");
      model(65536);
      send(0, 1'b1);
      settle();
      n_tests++;
      if (wr_addr.size() != exp_addr.size()) begin
         n_fail++; $display("FAIL unb_open_nwr got %0d want %0d", wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
         n_tests++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL unb_open_wr[%0d] got %0d=%0h want %0d=%0h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
      n_tests++;
      if (err_unbalanced !== 1'b1 || loaded !== 1'b0 || prog_len !== 16'd0) begin
         n_fail++; $display("FAIL unb_open_flags got unb=%b ld=%b len=%0d want 1/0/0", err_unbalanced, loaded, prog_len);
      end
   endtask

   task automatic test_overflow();
      sel_small = 1'b1;
      restart();
      set_stim("++++++++");
      model(8);
      send(0, 1'b1);
      settle();
      n_tests++;
      if (wr_addr.size() != exp_addr.size()) begin
         n_fail++; $display("FAIL ovf_nwr got %0d want %0d", wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
         n_tests++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL ovf_wr[%0d] got %0d=%0h want %0d=%0h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
      n_tests++;
      if (err_overflow !== 1'b1 || err_unbalanced !== 1'b0 || byte_ready !== 1'b0) begin
         n_fail++; $display("FAIL ovf_flag got ovf=%b unb=%b rdy=%b want 1/0/0", err_overflow, err_unbalanced, byte_ready);
      end
      pulse_load_start();
      clear_log();
      set_stim(">");
      model(8);
      send(0, 1'b1);
      settle();
      n_tests++;
      if (wr_addr.size() != 2 || wr_addr[0] !== 0 || wr_data[0] !== 8'h3E || wr_addr[1] !== 1 || wr_data[1] !== 0) begin
         n_fail++; $display("FAIL ovf_reload_wr got %0d writes want 0=3e,1=00", wr_addr.size());
      end
      n_tests++;
      if (prog_len !== 16'(exp_len) || err_overflow !== 1'b0 || loaded !== 1'b1) begin
         n_fail++; $display("FAIL ovf_reload got len=%0d ovf=%b ld=%b want %0d/0/1", prog_len, err_overflow, loaded, exp_len);
      end
      sel_small = 1'b0;
   endtask

   task automatic test_back_to_back();
      restart();
      set_stim("++");
      model(65536);
      send(1, 1'b1);
      settle();
      n_tests++;
      if (wr_addr.size() != exp_addr.size()) begin
         n_fail++; $display("FAIL bp_nwr got %0d want %0d", wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
         n_tests++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL bp_wr[%0d] got %0d=%0h want %0d=%0h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
      n_tests++;
      if (prog_len !== 16'd2 || loaded !== 1'b1) begin
         n_fail++; $display("FAIL bp_run got len=%0d ld=%b want 2/1", prog_len, loaded);
      end
      pulse_load_start();
      #1;
      n_tests++;
      if (core_reset !== 1'b1 || byte_ready !== 1'b1 || prog_len !== 16'd0 || loaded !== 1'b0) begin
         n_fail++; $display("FAIL bp_reload got cr=%b rdy=%b len=%0d ld=%b want 1/1/0/0", core_reset, byte_ready, prog_len, loaded);
      end
   endtask

   task automatic test_reset_midload();
      restart();
      set_stim("+-<");
      send(0, 1'b0);
      reset = 1'b1;
      @(negedge clock); #1;
      n_tests++;
      if (prog_we !== 1'b0 || prog_addr !== 16'd0 || prog_data !== 8'd0 || prog_len !== 16'd0) begin
         n_fail++; $display("FAIL mid_rst_data got we=%b a=%0d d=%0h len=%0d want 0/0/0/0", prog_we, prog_addr, prog_data, prog_len);
      end
      n_tests++;
      if (byte_ready !== 1'b0 || core_reset !== 1'b1 || loaded !== 1'b0 || err_overflow !== 1'b0 || err_unbalanced !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_ctrl got rdy=%b cr=%b ld=%b err=%b%b want 0/1/0/00", byte_ready, core_reset, loaded, err_overflow, err_unbalanced);
      end
      reset = 1'b0;
      @(negedge clock);
      clear_log();
      set_stim(".");
      send(0, 1'b1);
      settle();
      n_tests++;
      if (wr_addr.size() != 2 || wr_addr[0] !== 0 || wr_data[0] !== 8'h2E || wr_addr[1] !== 1 || wr_data[1] !== 0) begin
         n_fail++; $display("FAIL mid_reload got %0d writes want 0=2e,1=00", wr_addr.size());
      end
   endtask

   task automatic test_random();
      string cmd6;
      int    len, open, r, cap;
      bit    bal;
      cmd6 = "+-<>.,";
      for (int it = 0; it < 24; it++) begin
         sel_small = (it % 3 == 0);
         cap = sel_small ? 8 : 65536;
         restart();
         stim.delete();
         len  = $urandom_range(1, 24);
         open = 0;
         bal  = 1'($urandom_range(0, 1));
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) stim.push_back(8'($urandom_range(0, 255)));
            else if (r == 2) begin stim.push_back(8'h5B); open++; end
            else if (r == 3 && (!bal || open > 0)) begin
               stim.push_back(8'h5D);
               if (open > 0) open--;
            end else stim.push_back(cmd6[$urandom_range(0, 5)]);
         end
         if (bal) while (open > 0) begin stim.push_back(8'h5D); open--; end
         model(cap);
         send(2, 1'b1);
         settle();
         n_tests++;
         if (wr_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL rand%0d_nwr got %0d want %0d", it, wr_addr.size(), exp_addr.size());
         end
         for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            n_tests++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
               n_fail++; $display("FAIL rand%0d_wr[%0d] got %0d=%0h want %0d=%0h", it, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
         end
         n_tests++;
         if (prog_len !== 16'(exp_len) || loaded !== exp_run || core_reset !== !exp_run ||
             err_overflow !== exp_ovf || err_unbalanced !== exp_unb) begin
            n_fail++; $display("FAIL rand%0d_status got len=%0d ld=%b cr=%b ovf=%b unb=%b want %0d/%b/%b/%b/%b",
               it, prog_len, loaded, core_reset, err_overflow, err_unbalanced, exp_len, exp_run, !exp_run, exp_ovf, exp_unb);
         end
      end
      sel_small = 1'b0;
   endtask

   initial begin
      reset = 1'b1; byte_valid = 1'b0; byte_last = 1'b0; load_start = 1'b0; byte_in = 8'h00;
      test_reset();
      test_basic();
      test_filter();
      test_unbalanced();
      test_overflow();
      test_back_to_back();
      test_reset_midload();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
